// File: rtl/mem_op_sequencer.sv
// mem_op_sequencer: T0..T7 control-step FSM for ldw/ldwi/stw.
// Moore strobes, ready/timeout wait states, illegal-opcode abort.
module mem_op_sequencer #(
  parameter int               OPC_W    = 5,
  parameter int               OPC_MSB  = 31,
  parameter logic [OPC_W-1:0] OP_LDW   = 5'b00000,
  parameter logic [OPC_W-1:0] OP_LDWI  = 5'b00001,
  parameter logic [OPC_W-1:0] OP_STW   = 5'b00010,
  parameter logic [OPC_W-1:0] OP_ADD   = 5'b00011,
  parameter int               WAIT_MAX = 15,
  parameter int               CNT_W    = 4
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic             Mem_ready,
  input  logic [31:0]      IR_in,
  output logic             Busy,
  output logic             Done,
  output logic             Illegal,
  output logic             Mem_err,
  output logic [3:0]       Step,
  output logic             PCout,
  output logic             IncPC,
  output logic             PC_enable,
  output logic             MAR_enable,
  output logic             MDR_read,
  output logic             MDR_enable,
  output logic             MDRout,
  output logic             IR_enable,
  output logic             RAM_write,
  output logic             Gra,
  output logic             Grb,
  output logic             R_in,
  output logic             R_out,
  output logic             BAout,
  output logic             Y_enable,
  output logic             ZLowIn,
  output logic             ZLowout,
  output logic             Cout,
  output logic [OPC_W-1:0] Alu_op
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [OPC_W-1:0] op;
  logic [CNT_W-1:0] cnt;

  logic is_ldw;
  logic is_ldwi;
  logic is_stw;
  logic legal;
  logic in_wait;
  logic tmo;
  logic unused_ir;

  assign unused_ir = ^IR_in;

  assign is_ldw  = (op == OP_LDW);
  assign is_ldwi = (op == OP_LDWI);
  assign is_stw  = (op == OP_STW);
  assign legal   = is_ldw | is_ldwi | is_stw;

  assign in_wait = (state == S_T1)
                 | ((state == S_T6) & is_ldw)
                 | ((state == S_T7) & is_stw);

  assign tmo = (WAIT_MAX != 0) && in_wait && !Mem_ready
            && (cnt == CNT_W'(WAIT_MAX - 1));

  // next-step selection from current step, opcode and memory handshake
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = Start ? S_T0 : S_IDLE;
      S_T0:   nxt = S_T1;
      S_T1: begin
        if (Mem_ready) nxt = S_T2;
        else if (tmo)  nxt = S_IDLE;
      end
      S_T2:   nxt = S_T3;
      S_T3:   nxt = legal ? S_T4 : S_IDLE;
      S_T4:   nxt = S_T5;
      S_T5:   nxt = is_ldwi ? S_IDLE : S_T6;
      S_T6: begin
        if (!is_ldw)        nxt = S_T7;
        else if (Mem_ready) nxt = S_T7;
        else if (tmo)       nxt = S_IDLE;
      end
      S_T7: begin
        if (!is_stw)        nxt = S_IDLE;
        else if (Mem_ready) nxt = S_IDLE;
        else if (tmo)       nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // step register, opcode latch and wait-cycle counter
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_IDLE;
      op    <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      // opcode is captured as T3 is entered so T3 strobes stay a state decode
      if (state == S_T2) op <= IR_in[OPC_MSB -: OPC_W];
      // staying in a wait state implies Mem_ready was low
      if (in_wait && (nxt == state)) cnt <= cnt + CNT_W'(1);
      else                           cnt <= '0;
    end
  end

  // strobe decode; only Done/Mem_err in wait states see Mem_ready
  always_comb begin
    Busy       = (state != S_IDLE);
    Step       = state;
    Done       = 1'b0;
    Illegal    = 1'b0;
    Mem_err    = 1'b0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    PC_enable  = 1'b0;
    MAR_enable = 1'b0;
    MDR_read   = 1'b0;
    MDR_enable = 1'b0;
    MDRout     = 1'b0;
    IR_enable  = 1'b0;
    RAM_write  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    R_in       = 1'b0;
    R_out      = 1'b0;
    BAout      = 1'b0;
    Y_enable   = 1'b0;
    ZLowIn     = 1'b0;
    ZLowout    = 1'b0;
    Cout       = 1'b0;
    Alu_op     = '0;
    case (state)
      S_T0: begin
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        ZLowIn     = 1'b1;
      end
      S_T1: begin
        ZLowout    = 1'b1;
        PC_enable  = 1'b1;
        MDR_read   = 1'b1;
        MDR_enable = 1'b1;
        Mem_err    = tmo;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        Grb      = legal;
        BAout    = legal;
        Y_enable = legal;
        Illegal  = !legal;
      end
      S_T4: begin
        Cout   = 1'b1;
        ZLowIn = 1'b1;
        Alu_op = OP_ADD;
      end
      S_T5: begin
        ZLowout = 1'b1;
        unique case (1'b1)
          is_ldwi: begin
            Gra  = 1'b1;
            R_in = 1'b1;
            Done = 1'b1;
          end
          default: MAR_enable = 1'b1;
        endcase
      end
      S_T6: begin
        MDR_enable = 1'b1;
        unique case (1'b1)
          is_ldw: begin
            MDR_read = 1'b1;
            Mem_err  = tmo;
          end
          default: begin
            Gra   = 1'b1;
            R_out = 1'b1;
          end
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          is_stw: begin
            RAM_write = 1'b1;
            Done      = Mem_ready;
            Mem_err   = tmo;
          end
          default: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            R_in   = 1'b1;
            Done   = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule
